time_set_ctrl: RTL and testbench
================================

Name: time_set_ctrl

Overview:
- Mode/edit controller for the HH:MM:SS time counter.
- Runs the counter in normal mode and sequences user time-setting from three debounced buttons: mode, increment, decrement.
- Issues a one-cycle load of hour/min (sec forced to 0) into the counter.
- Produces the 4-digit display value plus per-digit blink blanking for the 7-segment driver.

Parameters:
- TIMEOUT_TICKS, 100: ticks with no button activity in a set state before the edit is abandoned (10 s at 10 Hz).
- BLINK_TICKS, 5: ticks per blink half-period of the field being edited.
- REPEAT_DLY, 5: hold ticks before auto-repeat starts (used only with the optional feature).

Ports:
- i_clk, input, 1: system clock.
- i_rst_n, input, 1: reset, asynchronous, active-low.
- i_tick, input, 1: one-cycle strobe at 10 Hz from the prescaler.
- i_btn_mode, input, 1: debounced level, active-high.
- i_btn_inc, input, 1: debounced level, active-high.
- i_btn_dec, input, 1: debounced level, active-high.
- i_cur_hour, input, 5: live counter hour, 0..23.
- i_cur_min, input, 6: live counter minute, 0..59.
- o_run_en, output, 1: counter count enable.
- o_load, output, 1: one-cycle load strobe to the counter.
- o_load_hour, output, 5: hour value to load.
- o_load_min, output, 6: minute value to load.
- o_mode, output, 2: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 COMMIT.
- o_disp_data, output, 14: decimal display value hour*100+min, range 0..2359.
- o_digit_blank, output, 4: per-digit blank; bit3 = leftmost digit.

Behaviour:
- Reset values (async): state RUN, o_run_en=1, o_load=0, o_load_hour=0, o_load_min=0, o_mode=0, o_disp_data=0, o_digit_blank=0, edit regs=0, timeout and blink counters=0, blink phase=0, button history=0.
- Button presses: each button is registered once; a press is the rising edge (prev=0, cur=1), producing a one-cycle step pulse. Held levels give no further pulses (without the optional feature).
- Priority within a cycle: mode > inc/dec. Simultaneous inc and dec: both ignored.
- FSM, RUN:
  - o_run_en=1.
  - Mode press -> SET_HOUR. Same edge captures edit_hour<=i_cur_hour, edit_min<=i_cur_min, clears the timeout and blink counters.
- FSM, SET_HOUR:
  - o_run_en=0.
  - inc: 23->0 wrap, else +1. dec: 0->23 wrap, else -1.
  - Mode press -> SET_MIN.
- FSM, SET_MIN:
  - o_run_en=0.
  - inc/dec on edit_min, 0..59, wrapping 59->0 and 0->59.
  - Mode press -> COMMIT.
- FSM, COMMIT:
  - Lasts one cycle: o_load=1, o_load_hour=edit_hour, o_load_min=edit_min.
  - Next state RUN; o_run_en returns to 1 the cycle after the load.
- Timeout:
  - In SET_HOUR/SET_MIN, the counter increments on i_tick and clears on any accepted step.
  - Reaching TIMEOUT_TICKS -> RUN with no load; the counter resumes from its frozen value.
- Blink:
  - Phase toggles every BLINK_TICKS ticks in set states and is cleared on any step, so the edited field is visible immediately.
  - SET_HOUR with phase=1: o_digit_blank=4'b1100.
  - SET_MIN with phase=1: o_digit_blank=4'b0011.
  - Otherwise 0.
- Display:
  - Registered. RUN/COMMIT show i_cur_hour*100+i_cur_min; set states show edit_hour*100+edit_min.
  - 14-bit result, no overflow possible.
- Latency: button level rising in cycle T -> edit reg updated at edge T+1 -> o_disp_data valid after edge T+2.
- Reset mid-edit returns to RUN with no load pulse.
- i_tick coincident with a step: the step wins and the timeout counter clears.

Optional Feature:
- Macro: TIME_SET_AUTO_REPEAT_EN.
- Defined: in SET_HOUR/SET_MIN, inc or dec held for REPEAT_DLY ticks then generates one extra step per i_tick while held. Repeat steps also clear the timeout.
- Undefined: steps are generated only on rising edges; the REPEAT_DLY parameter is unused.

Decomposition:
- Package time_ctrl_pkg holds: state enum (RUN, SET_HOUR, SET_MIN, COMMIT), HOUR_MAX=23, MIN_MAX=59, DISP_W=14.
- One sub-module: btn_step_gen, instantiated three times. It does registered edge detection and, when TIME_SET_AUTO_REPEAT_EN is defined, the hold-repeat counter. It outputs a one-cycle step pulse.

Test Plan:
- Reset release with i_cur_hour=12, i_cur_min=34 -> o_mode=0, o_run_en=1, o_disp_data=1234 after 1 cycle, o_load never asserted.
- Mode press, 2 inc, mode, 3 dec, mode, starting from 23:01 -> hour wraps to 1, min goes 01->58, single o_load with hour=1, min=58; o_run_en=1 the next cycle.
- SET_MIN, inc and dec rise in the same cycle -> edit_min unchanged; same-cycle mode and inc -> state advances, value unchanged.
- SET_HOUR, no buttons for 100 ticks -> return to RUN on the 100th tick, o_load=0; o_digit_blank toggles 4'b1100/0 every 5 ticks before that.
- Assert i_rst_n low during SET_MIN after edits -> all outputs at reset values asynchronously; after release, state RUN with no load pulse.
- With TIME_SET_AUTO_REPEAT_EN defined, hold inc in SET_MIN from 00 for 5+10 ticks -> edit_min=11 (1 edge step + 10 repeats); without the macro -> edit_min=1.

Source files
------------

// File: rtl/time_set_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// time_ctrl_pkg
//   Shared types and constants for the time-setting controller.
//   - state_e : controller mode, encoded so it can drive o_mode directly
//   - HOUR_MAX / MIN_MAX : field wrap limits
//   - DISP_W  : width of the decimal HHMM display value (max 2359)
//   - step_wrap() : +/-1 with wrap inside 0..max
//   - to_disp()   : hour*100 + min
// ---------------------------------------------------------------------------
package time_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        COMMIT   = 2'd3
    } state_e;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int DISP_W   = 14;

    // One step up or down on a field that wraps between 0 and max.
    function automatic logic [5:0] step_wrap(input logic [5:0] v,
                                             input logic [5:0] max,
                                             input logic       up);
        logic [5:0] r;
        if (up) r = (v == max)  ? 6'd0 : v + 6'd1;
        else    r = (v == 6'd0) ? max  : v - 6'd1;
        return r;
    endfunction

    function automatic logic [DISP_W-1:0] to_disp(input logic [4:0] h,
                                                  input logic [5:0] m);
        return DISP_W'(h) * DISP_W'(100) + DISP_W'(m);
    endfunction

endpackage

// File: rtl/time_set_ctrl_btn_step_gen.sv
// ---------------------------------------------------------------------------
// btn_step_gen
//   Turns one debounced button level into a one-cycle step pulse.
//   A step fires on the rising edge of the level. When the build defines
//   TIME_SET_AUTO_REPEAT_EN, a held button (with i_rep_en high) also fires
//   one step per i_tick once it has been held for REPEAT_DLY ticks.
//
//   Ports:
//     i_clk, i_rst_n : clock, async active-low reset
//     i_tick         : 10 Hz strobe (repeat timing only)
//     i_btn          : debounced button level
//     i_rep_en       : allow auto-repeat (controller is in a set state)
//     o_step         : one-cycle step pulse
// ---------------------------------------------------------------------------
module btn_step_gen #(
    parameter int REPEAT_DLY = 5
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_btn,
    input  logic i_rep_en,
    output logic o_step
);

    logic btn_q;
    logic edge_step;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) btn_q <= 1'b0;
        else          btn_q <= i_btn;
    end

    assign edge_step = i_btn & ~btn_q;

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int HW = (REPEAT_DLY < 1) ? 1 : $clog2(REPEAT_DLY + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(REPEAT_DLY);

    logic [HW-1:0] hold_q, hold_d;
    logic          rep_step;

    // Hold counter only advances once the press edge has passed (btn_q=1),
    // so the edge cycle itself never doubles as a repeat.
    always_comb begin
        hold_d   = hold_q;
        rep_step = 1'b0;
        if (!i_btn || !i_rep_en) begin
            hold_d = '0;
        end else if (btn_q && i_tick) begin
            if (hold_q == HOLD_MAX) rep_step = 1'b1;
            else                    hold_d   = hold_q + HW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) hold_q <= '0;
        else          hold_q <= hold_d;
    end

    assign o_step = edge_step | rep_step;
`else
    logic        unused_rep;
    logic [31:0] unused_dly;
    assign unused_rep = ^{i_tick, i_rep_en};
    assign unused_dly = 32'(REPEAT_DLY);
    assign o_step     = edge_step;
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
//   Mode/edit controller for the HH:MM:SS counter. RUN lets the counter
//   count; mode presses walk SET_HOUR -> SET_MIN -> COMMIT, where a one-cycle
//   load of the edited hour/min is issued (counter forces sec to 0).
//   Idle set states time out back to RUN without loading. Also produces the
//   registered HHMM display value and blink blanking for the edited field.
//
//   Optional feature macro: TIME_SET_AUTO_REPEAT_EN (hold inc/dec to repeat).
//
//   Ports:
//     i_clk, i_rst_n             : clock, async active-low reset
//     i_tick                     : 10 Hz strobe
//     i_btn_mode/inc/dec         : debounced button levels
//     i_cur_hour, i_cur_min      : live counter value
//     o_run_en                   : counter count enable
//     o_load, o_load_hour/min    : load strobe and value
//     o_mode                     : 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 COMMIT
//     o_disp_data                : hour*100+min
//     o_digit_blank              : per-digit blank, bit3 = leftmost
// ---------------------------------------------------------------------------
module time_set_ctrl
    import time_ctrl_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 100,
    parameter int BLINK_TICKS   = 5,
    parameter int REPEAT_DLY    = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_tick,
    input  logic              i_btn_mode,
    input  logic              i_btn_inc,
    input  logic              i_btn_dec,
    input  logic [4:0]        i_cur_hour,
    input  logic [5:0]        i_cur_min,
    output logic              o_run_en,
    output logic              o_load,
    output logic [4:0]        o_load_hour,
    output logic [5:0]        o_load_min,
    output logic [1:0]        o_mode,
    output logic [DISP_W-1:0] o_disp_data,
    output logic [3:0]        o_digit_blank
);

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam int BW = (BLINK_TICKS < 2) ? 1 : $clog2(BLINK_TICKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_TICKS - 1);

    state_e            state_q, state_d;
    logic [4:0]        edit_hour_q, edit_hour_d;
    logic [5:0]        edit_min_q, edit_min_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [BW-1:0]     blk_q, blk_d;
    logic              phase_q, phase_d;
    logic [DISP_W-1:0] disp_q, disp_d;

    logic mode_step, inc_step, dec_step;
    logic set_st, set_nxt, edit_step, timeout, clr;

    assign set_st = (state_q == SET_HOUR) || (state_q == SET_MIN);

    // ---------------- button step generators ----------------
    btn_step_gen #(.REPEAT_DLY(REPEAT_DLY)) u_btn_mode (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tick(i_tick),
        .i_btn(i_btn_mode), .i_rep_en(1'b0), .o_step(mode_step)
    );
    btn_step_gen #(.REPEAT_DLY(REPEAT_DLY)) u_btn_inc (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tick(i_tick),
        .i_btn(i_btn_inc), .i_rep_en(set_st), .o_step(inc_step)
    );
    btn_step_gen #(.REPEAT_DLY(REPEAT_DLY)) u_btn_dec (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tick(i_tick),
        .i_btn(i_btn_dec), .i_rep_en(set_st), .o_step(dec_step)
    );

    // Mode outranks inc/dec; inc and dec together cancel out.
    assign edit_step = set_st && !mode_step && (inc_step ^ dec_step);
    // A step in the same cycle as the final tick wins over the timeout.
    assign timeout   = set_st && i_tick && !mode_step && !edit_step &&
                       (tmo_q == TMO_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= RUN;
        else          state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:      if (mode_step) state_d = SET_HOUR;
            SET_HOUR: if (mode_step) state_d = SET_MIN;
                      else if (timeout) state_d = RUN;
            SET_MIN:  if (mode_step) state_d = COMMIT;
                      else if (timeout) state_d = RUN;
            COMMIT:   state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_run_en      = (state_q == RUN);
        o_load        = (state_q == COMMIT);
        o_mode        = state_q;
        o_digit_blank = 4'b0000;
        if (phase_q) begin
            if (state_q == SET_HOUR) o_digit_blank = 4'b1100;
            if (state_q == SET_MIN)  o_digit_blank = 4'b0011;
        end
    end

    // Edit regs only change in set states, so they double as the load value.
    assign o_load_hour = edit_hour_q;
    assign o_load_min  = edit_min_q;
    assign o_disp_data = disp_q;

    // ---------------- datapath next-state ----------------
    assign set_nxt = (state_d == SET_HOUR) || (state_d == SET_MIN);
    // Restart timeout and blink on any accepted step and whenever we are not
    // headed for a set state; phase 0 makes the edited field visible at once.
    assign clr     = mode_step || edit_step || !set_nxt;

    always_comb begin
        edit_hour_d = edit_hour_q;
        edit_min_d  = edit_min_q;
        if (state_q == RUN && mode_step) begin
            edit_hour_d = i_cur_hour;
            edit_min_d  = i_cur_min;
        end else if (edit_step) begin
            if (state_q == SET_HOUR)
                edit_hour_d = 5'(step_wrap({1'b0, edit_hour_q}, 6'(HOUR_MAX), inc_step));
            else
                edit_min_d  = step_wrap(edit_min_q, 6'(MIN_MAX), inc_step);
        end
    end

    always_comb begin
        tmo_d   = tmo_q;
        blk_d   = blk_q;
        phase_d = phase_q;
        if (clr) begin
            tmo_d   = '0;
            blk_d   = '0;
            phase_d = 1'b0;
        end else if (i_tick) begin
            tmo_d = tmo_q + TW'(1);
            if (blk_q == BLK_LAST) begin
                blk_d   = '0;
                phase_d = ~phase_q;
            end else begin
                blk_d = blk_q + BW'(1);
            end
        end
    end

    always_comb begin
        disp_d = set_st ? to_disp(edit_hour_q, edit_min_q)
                        : to_disp(i_cur_hour, i_cur_min);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            edit_hour_q <= '0;
            edit_min_q  <= '0;
            tmo_q       <= '0;
            blk_q       <= '0;
            phase_q     <= 1'b0;
            disp_q      <= '0;
        end else begin
            edit_hour_q <= edit_hour_d;
            edit_min_q  <= edit_min_d;
            tmo_q       <= tmo_d;
            blk_q       <= blk_d;
            phase_q     <= phase_d;
            disp_q      <= disp_d;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_time_set_ctrl
//   Directed bench for time_set_ctrl with a behavioural reference model and
//   per-cycle output comparison, plus literal expectations per scenario.
// ---------------------------------------------------------------------------
module tb_time_set_ctrl;

    localparam int TMO  = 100;
    localparam int BLK  = 5;
    localparam int RDLY = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        bm = 1'b0, bi = 1'b0, bd = 1'b0;
    logic [4:0]  ch = '0;
    logic [5:0]  cm = '0;

    logic        o_run_en, o_load;
    logic [4:0]  o_load_hour;
    logic [5:0]  o_load_min;
    logic [1:0]  o_mode;
    logic [13:0] o_disp_data;
    logic [3:0]  o_digit_blank;

    int checks = 0;
    int failures = 0;
    int loads = 0;

    time_set_ctrl #(.TIMEOUT_TICKS(TMO), .BLINK_TICKS(BLK), .REPEAT_DLY(RDLY)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick),
        .i_btn_mode(bm), .i_btn_inc(bi), .i_btn_dec(bd),
        .i_cur_hour(ch), .i_cur_min(cm),
        .o_run_en(o_run_en), .o_load(o_load),
        .o_load_hour(o_load_hour), .o_load_min(o_load_min),
        .o_mode(o_mode), .o_disp_data(o_disp_data), .o_digit_blank(o_digit_blank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode 0..3, edit value, idle ticks since the last step/entry; blink
    // phase is just (idle / BLK) odd, timeout is idle reaching TMO.
    int m_mode, m_eh, m_em, m_idle, m_disp, m_hci, m_hcd;
    bit m_pm, m_pi, m_pd;
    bit mp, ip, dp, set;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_eh = 0; m_em = 0; m_idle = 0; m_disp = 0;
            m_hci = 0; m_hcd = 0; m_pm = 0; m_pi = 0; m_pd = 0;
        end else begin
            set = (m_mode == 1 || m_mode == 2);
            mp  = bm && !m_pm;
            ip  = bi && !m_pi;
            dp  = bd && !m_pd;
`ifdef TIME_SET_AUTO_REPEAT_EN
            if (!(bi && set)) m_hci = 0;
            else if (m_pi && tick) begin
                if (m_hci >= RDLY) ip = 1; else m_hci++;
            end
            if (!(bd && set)) m_hcd = 0;
            else if (m_pd && tick) begin
                if (m_hcd >= RDLY) dp = 1; else m_hcd++;
            end
`endif
            m_disp = set ? m_eh * 100 + m_em : ch * 100 + cm;
            case (m_mode)
                0: if (mp) begin m_mode = 1; m_eh = ch; m_em = cm; m_idle = 0; end
                1, 2: begin
                    if (mp) begin
                        m_mode++; m_idle = 0;
                    end else if (ip != dp) begin
                        if (m_mode == 1) m_eh = ip ? (m_eh + 1) % 24 : (m_eh + 23) % 24;
                        else             m_em = ip ? (m_em + 1) % 60 : (m_em + 59) % 60;
                        m_idle = 0;
                    end else if (tick) begin
                        m_idle++;
                        if (m_idle == TMO) begin m_mode = 0; m_idle = 0; end
                    end
                end
                default: m_mode = 0;
            endcase
            m_pm = bm; m_pi = bi; m_pd = bd;
        end
    end

    function automatic int exp_blank();
        if ((m_idle / BLK) % 2 == 1) begin
            if (m_mode == 1) return 12;
            if (m_mode == 2) return 3;
        end
        return 0;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("mode",   o_mode, m_mode);
            chk("run_en", o_run_en, m_mode == 0);
            chk("load",   o_load, m_mode == 3);
            chk("disp",   o_disp_data, m_disp);
            chk("blank",  o_digit_blank, exp_blank());
            if (m_mode == 3) begin
                chk("load_hour", o_load_hour, m_eh);
                chk("load_min",  o_load_min, m_em);
            end
            if (o_load) loads++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int which);
        case (which)
            0: bm = 1'b1;
            1: bi = 1'b1;
            default: bd = 1'b1;
        endcase
        cyc();
        bm = 1'b0; bi = 1'b0; bd = 1'b0;
        cyc();
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // reset state
        ch = 5'd12; cm = 6'd34;
        #3;
        chk("rst_mode", o_mode, 0);
        chk("rst_run_en", o_run_en, 1);
        chk("rst_load", o_load, 0);
        chk("rst_disp", o_disp_data, 0);
        chk("rst_blank", o_digit_blank, 0);
        chk("rst_load_hour", o_load_hour, 0);
        chk("rst_load_min", o_load_min, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();
        chk("disp_after_rst", o_disp_data, 1234);
        repeat (3) cyc();
        chk("no_load_at_start", loads, 0);

        // full edit from 23:01 -> 01:58
        ch = 5'd23; cm = 6'd1;
        cyc();
        press(0);
        chk("enter_set_hour", o_mode, 1);
        chk("run_en_off", o_run_en, 0);
        press(1); press(1);
        chk("hour_wrap_disp", o_disp_data, 101);
        press(0);
        chk("enter_set_min", o_mode, 2);
        press(2); press(2); press(2);
        chk("min_wrap_disp", o_disp_data, 158);
        bm = 1'b1;
        cyc();
        chk("commit_load", o_load, 1);
        chk("commit_hour", o_load_hour, 1);
        chk("commit_min", o_load_min, 58);
        chk("commit_run_en", o_run_en, 0);
        bm = 1'b0;
        cyc();
        chk("post_commit_run_en", o_run_en, 1);
        chk("post_commit_load", o_load, 0);
        chk("one_load", loads, 1);

        // inc+dec together, then mode+inc together
        ch = 5'd1; cm = 6'd58;
        cyc();
        press(0); press(0);
        bi = 1'b1; bd = 1'b1;
        cyc();
        bi = 1'b0; bd = 1'b0;
        cyc();
        chk("incdec_ignored", o_disp_data, 158);
        bm = 1'b1; bi = 1'b1;
        cyc();
        chk("mode_beats_inc", o_mode, 3);
        chk("mode_beats_inc_min", o_load_min, 58);
        bm = 1'b0; bi = 1'b0;
        cyc();
        chk("back_to_run", o_mode, 0);

        // timeout and blink
        ch = 5'd5; cm = 6'd30;
        cyc();
        press(0);
        tick_n(4);
        chk("blink_tick4", o_digit_blank, 0);
        tick_n(1);
        chk("blink_tick5", o_digit_blank, 12);
        tick_n(5);
        chk("blink_tick10", o_digit_blank, 0);
        tick_n(89);
        chk("tick99_still_set", o_mode, 1);
        tick_n(1);
        chk("timeout_run", o_mode, 0);
        chk("timeout_no_load", loads, 2);
        chk("timeout_disp", o_disp_data, 530);

        // async reset mid-edit
        press(0); press(0); press(1); press(1);
        chk("pre_reset_disp", o_disp_data, 532);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mode", o_mode, 0);
        chk("arst_run_en", o_run_en, 1);
        chk("arst_disp", o_disp_data, 0);
        chk("arst_blank", o_digit_blank, 0);
        chk("arst_load", o_load, 0);
        chk("arst_load_min", o_load_min, 0);
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("after_arst_mode", o_mode, 0);
        chk("after_arst_no_load", loads, 2);

        // hold inc in SET_MIN from 00
        ch = 5'd7; cm = 6'd0;
        cyc();
        press(0); press(0);
        bi = 1'b1;
        cyc();
        tick_n(15);
        bi = 1'b0;
        cyc(); cyc();
`ifdef TIME_SET_AUTO_REPEAT_EN
        chk("hold_inc", o_disp_data, 711);
`else
        chk("hold_inc", o_disp_data, 701);
`endif
        press(0);
        cyc();
        chk("final_loads", loads, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
